// File: rtl/i2c_bus_conditioner.sv
// i2c_bus_conditioner
// Per-channel I2C line conditioning: synchronise raw SCL/SDA, digitally
// debounce them, then decode START / STOP / data-bit events and track
// whether the bus is busy.
// Optional feature: define I2C_BUS_CONDITIONER_ARB_LOST_EN to enable the
// sticky arbitration-loss detector. When undefined, arb_lost is tied to 0.
module i2c_bus_conditioner #(
  parameter int NUM_CH      = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NUM_CH-1:0] scl_in,
  input  logic [NUM_CH-1:0] sda_in,
  input  logic [NUM_CH-1:0] sda_out,
  output logic [NUM_CH-1:0] scl_filt,
  output logic [NUM_CH-1:0] sda_filt,
  output logic [NUM_CH-1:0] start_det,
  output logic [NUM_CH-1:0] stop_det,
  output logic [NUM_CH-1:0] bit_valid,
  output logic [NUM_CH-1:0] bit_val,
  output logic [NUM_CH-1:0] bus_busy,
  output logic [NUM_CH-1:0] arb_lost
);

  localparam int NUM_LINES = 2 * NUM_CH;
  localparam int CNT_W     = $clog2(FILT_CYC + 1);
  // The filter toggles on the cycle the count would reach FILT_CYC, so the
  // stored count never needs to hold FILT_CYC itself.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Lines [NUM_CH-1:0] are SCL, lines [2*NUM_CH-1:NUM_CH] are SDA.
  logic [NUM_LINES-1:0] raw_lines;
  logic [NUM_LINES-1:0] filt_lines;

  assign raw_lines = {sda_in, scl_in};
  assign scl_filt  = filt_lines[NUM_CH-1:0];
  assign sda_filt  = filt_lines[NUM_LINES-1:NUM_CH];

  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   filt_reg;
    logic                   differ;

    assign differ = sync_reg[SYNC_STAGES-1] ^ filt_reg;

    // Metastability synchroniser; resets to the idle-high bus level.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        sync_reg <= '1;
      end else begin
        sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_lines[gi]};
      end
    end

    // Debounce: accept a change only after it persists FILT_CYC cycles.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        cnt_reg  <= '0;
        filt_reg <= 1'b1;
      end else if (!differ) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        cnt_reg  <= '0;
        filt_reg <= ~filt_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end

    assign filt_lines[gi] = filt_reg;
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic       scl_prev_reg;
    logic       sda_prev_reg;
    logic       start_reg;
    logic       stop_reg;
    logic       bv_reg;
    logic       bval_reg;
    logic [0:0] state_reg;
    logic [0:0] state_next;
    logic       start_cond;
    logic       stop_cond;
    logic       rise_cond;

    // SCL must be high on both sides of the SDA edge, which also rules out
    // a simultaneous SCL/SDA change being taken as START or STOP.
    assign start_cond = scl_prev_reg & scl_filt[gi] &  sda_prev_reg & ~sda_filt[gi];
    assign stop_cond  = scl_prev_reg & scl_filt[gi] & ~sda_prev_reg &  sda_filt[gi];
    assign rise_cond  = ~scl_prev_reg & scl_filt[gi];

    // Bus-state transition: START (incl. repeated) -> BUSY, STOP -> IDLE.
    always_comb begin
      state_next = state_reg;
      if (start_cond) begin
        state_next = ST_BUSY;
      end else if (stop_cond) begin
        state_next = ST_IDLE;
      end
    end

    // Edge history, registered event pulses and bus state.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        scl_prev_reg <= 1'b1;
        sda_prev_reg <= 1'b1;
        start_reg    <= 1'b0;
        stop_reg     <= 1'b0;
        bv_reg       <= 1'b0;
        bval_reg     <= 1'b0;
        state_reg    <= ST_IDLE;
      end else begin
        scl_prev_reg <= scl_filt[gi];
        sda_prev_reg <= sda_filt[gi];
        start_reg    <= start_cond;
        stop_reg     <= stop_cond;
        bv_reg       <= rise_cond;
        bval_reg     <= rise_cond & sda_filt[gi];
        state_reg    <= state_next;
      end
    end

    assign start_det[gi] = start_reg;
    assign stop_det[gi]  = stop_reg;
    assign bit_valid[gi] = bv_reg;
    assign bit_val[gi]   = bval_reg;
    assign bus_busy[gi]  = (state_reg == ST_BUSY);

`ifdef I2C_BUS_CONDITIONER_ARB_LOST_EN
    logic arb_reg;
    logic arb_set;

    // We released SDA but the bus reads low on a sampled bit: another
    // master won the bus.
    assign arb_set = bv_reg & (state_reg == ST_BUSY) & sda_out[gi] & ~sda_filt[gi];

    // Sticky loss flag; a new loss outranks a coincident STOP.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        arb_reg <= 1'b0;
      end else if (arb_set) begin
        arb_reg <= 1'b1;
      end else if (stop_reg) begin
        arb_reg <= 1'b0;
      end
    end

    assign arb_lost[gi] = arb_reg;
`else
    assign arb_lost[gi] = 1'b0;
`endif
  end

`ifndef I2C_BUS_CONDITIONER_ARB_LOST_EN
  // sda_out only feeds the arbitration detector.
  logic unused_sda_out;
  assign unused_sda_out = ^sda_out;
`endif

endmodule
